// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module  : uart_tx_serializer
// Brief   : Byte-wide UART transmitter, valid/ready in, LSB-first serial frames out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
  parameter int CLK_HZ    = 48000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       uart_tx
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        C_DATA_LAST = 4'd7;
  localparam logic [3:0]        C_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic              C_PAR_EN    = (PARITY != 0);
  localparam logic              C_PAR_INV   = (PARITY == 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud_cnt;
  logic [3:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_parity;
  logic                r_ready;
  logic                r_line;

  wire w_accept   = tx_valid && r_ready;
  wire w_bit_done = (r_baud_cnt == C_BAUD_LAST);

  // Every transition sets the line level for the bit that starts on the
  // following cycle, so uart_tx always comes straight from a flop.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_ready    <= 1'b1;
      r_line     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
          r_line     <= 1'b1;
          if (w_accept) begin
            r_shift  <= tx_data;
            r_parity <= (^tx_data) ^ C_PAR_INV;
            r_ready  <= 1'b0;
            r_line   <= 1'b0;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_line     <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == C_DATA_LAST) begin
              r_bit_cnt <= '0;
              if (C_PAR_EN) begin
                r_line  <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_line  <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_line    <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_line     <= 1'b1;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          r_line <= 1'b1;
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == C_STOP_LAST) begin
              r_bit_cnt <= '0;
              r_ready   <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
          r_ready    <= 1'b1;
          r_line     <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready = r_ready;
  assign busy     = ~r_ready;
  assign uart_tx  = r_line;

endmodule

`default_nettype wire
